// File: rtl/fpga_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpga_config_loader_pkg
// Description : Shared constants for the configuration loader: default
//               geometry of the fabric configuration port, FSM state
//               encodings and small elaboration-time helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fpga_config_loader_pkg;

    // Default geometry, kept in one place so the fabric and its wrappers agree
    localparam int c_DEF_WORD_W        = 32;
    localparam int c_DEF_FRAME_W       = 320;
    localparam int c_DEF_NUM_FRAMES    = 172;
    localparam int c_DEF_SETTLE_CYCLES = 10;
    localparam int c_DEF_RDY_DELAY     = 10;

    // Loader FSM state encodings
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FILL   = 3'd1;
    localparam logic [2:0] c_ST_WRITE  = 3'd2;
    localparam logic [2:0] c_ST_SETTLE = 3'd3;
    localparam logic [2:0] c_ST_ARM    = 3'd4;
    localparam logic [2:0] c_ST_RUN    = 3'd5;

    // Width of a counter that runs 0..count-1; never narrower than one bit
    function automatic int f_cnt_width(input int count);
        return (count < 2) ? 1 : $clog2(count);
    endfunction

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_config_loader_frame_asm.sv
`default_nettype none
// ============================================================================
// Module      : fpga_config_loader_frame_asm
// Description : Assembles WORD_W-bit bitstream words into FRAME_W-bit frames,
//               MSB-first (first word of a frame ends up in the top bits).
//               frame/frame_done are combinational so the caller can capture
//               the completed frame on the same edge as its last word.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader_frame_asm
    import fpga_config_loader_pkg::*;
#(
    parameter int WORD_W  = c_DEF_WORD_W,
    parameter int FRAME_W = c_DEF_FRAME_W
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               accept,
    input  logic [WORD_W-1:0]  word,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_done
);

    localparam int WPF   = FRAME_W / WORD_W;
    localparam int CNT_W = f_cnt_width(WPF);
    localparam logic [CNT_W-1:0] c_LAST_WORD = CNT_W'(WPF - 1);

    logic [CNT_W-1:0] r_word_cnt;

    if ((FRAME_W % WORD_W) != 0) begin : g_width_check
        $error("fpga_config_loader_frame_asm: FRAME_W must be a multiple of WORD_W");
    end

    if (WPF == 1) begin : g_single
        // A frame is exactly one word; nothing to store
        assign frame = word;
    end else begin : g_multi
        logic [FRAME_W-WORD_W-1:0] r_shift;

        // Older words sit above the incoming one, so the frame reads MSB-first
        assign frame = {r_shift, word};

        // Shift each accepted word in at the bottom of the assembly register
        always_ff @(posedge clock or negedge rst_n) begin
            if (!rst_n) begin
                r_shift <= '0;
            end else if (accept) begin
                r_shift <= frame[FRAME_W-WORD_W-1:0];
            end
        end
    end

    assign frame_done = accept && (r_word_cnt == c_LAST_WORD);

    // Word position within the current frame; wraps after the last word
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt <= '0;
        end else if (clear) begin
            r_word_cnt <= '0;
        end else if (accept) begin
            r_word_cnt <= (r_word_cnt == c_LAST_WORD) ? '0 : r_word_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpga_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : fpga_config_loader
// Description : Bitstream loader for the fabric configuration port. Takes a
//               valid/ready word stream, writes each assembled frame with a
//               one-hot configs_en strobe, then enables the fabric FFs and
//               finally reports rdy. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module fpga_config_loader
    import fpga_config_loader_pkg::*;
#(
    parameter int WORD_W        = c_DEF_WORD_W,
    parameter int FRAME_W       = c_DEF_FRAME_W,
    parameter int NUM_FRAMES    = c_DEF_NUM_FRAMES,
    parameter int SETTLE_CYCLES = c_DEF_SETTLE_CYCLES,
    parameter int RDY_DELAY     = c_DEF_RDY_DELAY
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_W-1:0]     s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [FRAME_W-1:0]    configs_in,
    output logic [NUM_FRAMES-1:0] configs_en,
    output logic                  ff_en,
    output logic                  rdy,
    output logic                  busy
);

    localparam int IDX_W = f_cnt_width(NUM_FRAMES);
    localparam int DLY_W = f_cnt_width(f_max(SETTLE_CYCLES, RDY_DELAY));

    localparam logic [IDX_W-1:0]      c_LAST_IDX    = IDX_W'(NUM_FRAMES - 1);
    localparam logic [DLY_W-1:0]      c_SETTLE_LAST = DLY_W'(SETTLE_CYCLES - 1);
    localparam logic [DLY_W-1:0]      c_RDY_LAST    = DLY_W'(RDY_DELAY - 1);
    localparam logic [NUM_FRAMES-1:0] c_EN_ONE      = NUM_FRAMES'(1);

    if ((SETTLE_CYCLES < 1) || (RDY_DELAY < 1)) begin : g_delay_check
        $error("fpga_config_loader: SETTLE_CYCLES and RDY_DELAY must be at least 1");
    end

    logic [2:0]            r_state;
    logic [IDX_W-1:0]      r_frame_idx;
    logic [DLY_W-1:0]      r_delay_cnt;
    logic                  r_s_ready;
    logic [FRAME_W-1:0]    r_configs_in;
    logic [NUM_FRAMES-1:0] r_configs_en;
    logic                  r_ff_en;
    logic                  r_rdy;
    logic                  r_busy;

    logic                  w_accept;
    logic                  w_start_load;
    logic [FRAME_W-1:0]    w_frame;
    logic                  w_frame_done;

    // s_ready is only ever high in FILL, so accepts happen only there
    assign w_accept     = s_valid && r_s_ready;
    // start is honoured only when no load is in progress
    assign w_start_load = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_RUN));

    fpga_config_loader_frame_asm #(
        .WORD_W  (WORD_W),
        .FRAME_W (FRAME_W)
    ) u_frame_asm (
        .clock      (clock),
        .rst_n      (rst_n),
        .clear      (w_start_load),
        .accept     (w_accept),
        .word       (s_data),
        .frame      (w_frame),
        .frame_done (w_frame_done)
    );

    // Load sequencer: FILL/WRITE per frame, then SETTLE and ARM delays, then RUN.
    // SETTLE and ARM each last exactly their programmed number of cycles.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_frame_idx  <= '0;
            r_delay_cnt  <= '0;
            r_s_ready    <= 1'b0;
            r_configs_in <= '0;
            r_configs_en <= '0;
            r_ff_en      <= 1'b0;
            r_rdy        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_RUN: begin
                    if (w_start_load) begin
                        r_state     <= c_ST_FILL;
                        r_frame_idx <= '0;
                        r_s_ready   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_ff_en     <= 1'b0;
                        r_rdy       <= 1'b0;
                    end
                end
                c_ST_FILL: begin
                    if (w_frame_done) begin
                        r_configs_in <= w_frame;
                        r_configs_en <= c_EN_ONE << r_frame_idx;
                        r_s_ready    <= 1'b0;
                        r_state      <= c_ST_WRITE;
                    end
                end
                c_ST_WRITE: begin
                    r_configs_en <= '0;
                    if (r_frame_idx == c_LAST_IDX) begin
                        r_delay_cnt <= '0;
                        r_state     <= c_ST_SETTLE;
                    end else begin
                        r_frame_idx <= r_frame_idx + IDX_W'(1);
                        r_s_ready   <= 1'b1;
                        r_state     <= c_ST_FILL;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_delay_cnt == c_SETTLE_LAST) begin
                        r_delay_cnt <= '0;
                        r_ff_en     <= 1'b1;
                        r_state     <= c_ST_ARM;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + DLY_W'(1);
                    end
                end
                c_ST_ARM: begin
                    if (r_delay_cnt == c_RDY_LAST) begin
                        r_delay_cnt <= '0;
                        r_rdy       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_RUN;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + DLY_W'(1);
                    end
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_s_ready    <= 1'b0;
                    r_configs_en <= '0;
                    r_ff_en      <= 1'b0;
                    r_rdy        <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign configs_in = r_configs_in;
    assign configs_en = r_configs_en;
    assign ff_en      = r_ff_en;
    assign rdy        = r_rdy;
    assign busy       = r_busy;

endmodule
`default_nettype wire
